// File: rtl/gb_pkg.sv
// Shared definitions for the core: regfile indices, write-enable encodings
// and the stack sequencer state type.
package gb_pkg;

  localparam logic [3:0] REG_B   = 4'd0;
  localparam logic [3:0] REG_C   = 4'd1;
  localparam logic [3:0] REG_D   = 4'd2;
  localparam logic [3:0] REG_E   = 4'd3;
  localparam logic [3:0] REG_H   = 4'd4;
  localparam logic [3:0] REG_L   = 4'd5;
  localparam logic [3:0] REG_A   = 4'd6;
  localparam logic [3:0] REG_F   = 4'd7;

  localparam logic [3:0] PAIR_BC = 4'd0;
  localparam logic [3:0] PAIR_DE = 4'd2;
  localparam logic [3:0] PAIR_HL = 4'd4;
  localparam logic [3:0] PAIR_AF = 4'd6;
  localparam logic [3:0] REG_SP  = 4'd8;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_PAIR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_POP_LO,
    ST_POP_HI,
    ST_WB,
    ST_DONE
  } stack_state_t;

endpackage

// File: rtl/stack_seq_if.sv
// Bundle of control, regfile and memory-bus signals around the stack sequencer.
// master = the sequencer, slave = decoder/regfile/memory side.
interface stack_seq_if;

  logic        start;
  logic        op;
  logic [3:0]  pair;
  logic [15:0] sp_in;
  logic        busy;
  logic        done;
  logic [15:0] sp_out;
  logic        sp_we;

  logic [3:0]  rf_rd_reg;
  logic [7:0]  rf_rd_hi;
  logic [7:0]  rf_rd_lo;
  logic [1:0]  rf_wr_en;
  logic [3:0]  rf_wr_reg;
  logic [15:0] rf_wr_data;
  logic        rf_wr_flag;
  logic [7:0]  rf_flag_data;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport master (
    input  start, op, pair, sp_in, rf_rd_hi, rf_rd_lo, mem_rdata, mem_ready,
    output busy, done, sp_out, sp_we, rf_rd_reg, rf_wr_en, rf_wr_reg,
           rf_wr_data, rf_wr_flag, rf_flag_data, mem_addr, mem_wdata,
           mem_we, mem_re
  );

  modport slave (
    output start, op, pair, sp_in, rf_rd_hi, rf_rd_lo, mem_rdata, mem_ready,
    input  busy, done, sp_out, sp_we, rf_rd_reg, rf_wr_en, rf_wr_reg,
           rf_wr_data, rf_wr_flag, rf_flag_data, mem_addr, mem_wdata,
           mem_we, mem_re
  );

endinterface

// File: rtl/stack_seq.sv
// PUSH rr / POP rr sequencer: moves a regfile pair to/from memory as two byte
// transfers around SP and returns the updated SP.
module stack_seq #(
  parameter logic [3:0] PAIR_AF   = 4'd6,
  parameter logic [7:0] FLAG_MASK = 8'hF0
) (
  input  logic         clk,
  input  logic         rst,
  stack_seq_if.master  bus
);
  import gb_pkg::*;

  stack_state_t r_state;
  stack_state_t w_next;

  logic [15:0] r_sp;
  logic [15:0] r_sp_out;
  logic [3:0]  r_pair;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;

  logic [15:0] w_mem_addr;
  logic [7:0]  w_mem_wdata;
  logic        w_mem_we;
  logic        w_mem_re;
  logic [1:0]  w_rf_wr_en;
  logic [3:0]  w_rf_wr_reg;
  logic [15:0] w_rf_wr_data;
  logic        w_rf_wr_flag;
  logic [7:0]  w_rf_flag_data;
  logic        w_done;
  logic        w_sp_we;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp     <= '0;
      r_sp_out <= '0;
      r_pair   <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sp   <= bus.sp_in;
            r_pair <= bus.pair & 4'hE;
          end
        end
        ST_PUSH_LO: begin
          if (bus.mem_ready) r_sp_out <= r_sp - 16'd2;
        end
        ST_POP_LO: begin
          if (bus.mem_ready) r_lo <= bus.mem_rdata;
        end
        ST_POP_HI: begin
          if (bus.mem_ready) begin
            r_hi     <= bus.mem_rdata;
            r_sp_out <= r_sp + 16'd2;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next         = r_state;
    w_mem_addr     = '0;
    w_mem_wdata    = '0;
    w_mem_we       = 1'b0;
    w_mem_re       = 1'b0;
    w_rf_wr_en     = WE_NONE;
    w_rf_wr_reg    = '0;
    w_rf_wr_data   = '0;
    w_rf_wr_flag   = 1'b0;
    w_rf_flag_data = '0;
    w_done         = 1'b0;
    w_sp_we        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = bus.op ? ST_POP_LO : ST_PUSH_HI;
      end
      // Regfile read is combinational, so the pair bytes go straight to the bus.
      ST_PUSH_HI: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_sp - 16'd1;
        w_mem_wdata = bus.rf_rd_hi;
        if (bus.mem_ready) w_next = ST_PUSH_LO;
      end
      ST_PUSH_LO: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_sp - 16'd2;
        w_mem_wdata = bus.rf_rd_lo;
        if (bus.mem_ready) w_next = ST_DONE;
      end
      ST_POP_LO: begin
        w_mem_re   = 1'b1;
        w_mem_addr = r_sp;
        if (bus.mem_ready) w_next = ST_POP_HI;
      end
      ST_POP_HI: begin
        w_mem_re   = 1'b1;
        w_mem_addr = r_sp + 16'd1;
        if (bus.mem_ready) w_next = ST_WB;
      end
      ST_WB: begin
        w_rf_wr_en   = WE_PAIR;
        w_rf_wr_reg  = r_pair;
        w_rf_wr_data = {r_hi, r_lo};
        if (r_pair == PAIR_AF) begin
          w_rf_wr_flag   = 1'b1;
          w_rf_flag_data = r_lo & FLAG_MASK;
        end
        w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done  = 1'b1;
        w_sp_we = 1'b1;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.done         = w_done;
  assign bus.sp_we        = w_sp_we;
  assign bus.sp_out       = r_sp_out;
  assign bus.rf_rd_reg    = r_pair;
  assign bus.rf_wr_en     = w_rf_wr_en;
  assign bus.rf_wr_reg    = w_rf_wr_reg;
  assign bus.rf_wr_data   = w_rf_wr_data;
  assign bus.rf_wr_flag   = w_rf_wr_flag;
  assign bus.rf_flag_data = w_rf_flag_data;
  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_wdata    = w_mem_wdata;
  assign bus.mem_we       = w_mem_we;
  assign bus.mem_re       = w_mem_re;

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: memory/regfile environment, a
// transaction-level PUSH/POP model, directed corner cases and random ops.
module tb_stack_seq;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } xfer_t;

  logic clk;
  logic rst;
  stack_seq_if bus();

  stack_seq #(.PAIR_AF(4'd6), .FLAG_MASK(8'hF0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state (model) and environment state (what the DUT talks to).
  logic [7:0] exp_mem [65536];
  logic [7:0] exp_rf  [16];
  logic [7:0] exp_flag;
  logic [7:0] env_mem [65536];
  logic [7:0] env_rf  [16];
  logic [7:0] env_flag;

  int    ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int    sync_gen   = 0;
  int    sync_seen  = 0;
  xfer_t xq[$];
  int    done_cnt = 0;
  int    wr_cnt   = 0;
  int    excl_err = 0;
  logic [3:0]  last_wr_reg;
  logic [15:0] last_wr_data;
  logic        last_wr_flag;
  logic [7:0]  last_flag_data;

  assign bus.rf_rd_hi  = env_rf[bus.rf_rd_reg];
  assign bus.rf_rd_lo  = env_rf[bus.rf_rd_reg | 4'd1];
  assign bus.mem_rdata = env_mem[bus.mem_addr];

  // Environment: drives mem_ready, commits memory/regfile writes, logs traffic.
  always @(negedge clk) begin
    logic rdy;
    if (sync_seen != sync_gen) begin
      for (int i = 0; i < 65536; i++) env_mem[i] = exp_mem[i];
      for (int i = 0; i < 16; i++) env_rf[i] = exp_rf[i];
      env_flag  = exp_flag;
      sync_seen = sync_gen;
    end
    case (ready_mode)
      0:       rdy = 1'b1;
      1:       rdy = ($urandom_range(0, 2) != 0);
      default: rdy = 1'b0;
    endcase
    bus.mem_ready = rdy;
    if (rst) begin
      if (bus.mem_we && bus.mem_re) excl_err++;
      if (bus.mem_we && rdy) begin
        env_mem[bus.mem_addr] = bus.mem_wdata;
        xq.push_back({1'b1, bus.mem_addr, bus.mem_wdata});
      end
      if (bus.mem_re && rdy) xq.push_back({1'b0, bus.mem_addr, env_mem[bus.mem_addr]});
      if (bus.rf_wr_en != 2'b00) begin
        wr_cnt++;
        last_wr_reg    = bus.rf_wr_reg;
        last_wr_data   = bus.rf_wr_data;
        last_wr_flag   = bus.rf_wr_flag;
        last_flag_data = bus.rf_flag_data;
        if (bus.rf_wr_en == 2'b11) begin
          env_rf[bus.rf_wr_reg]        = bus.rf_wr_data[15:8];
          env_rf[bus.rf_wr_reg | 4'd1] = bus.rf_wr_data[7:0];
        end
        if (bus.rf_wr_flag) env_flag = bus.rf_flag_data;
      end
      if (bus.done) done_cnt++;
    end
  end

  // Transaction model results for the operation in flight.
  xfer_t       exp_q[$];
  logic [15:0] m_sp;
  int          m_lat;
  logic        m_op;
  logic [3:0]  m_pair;
  logic [7:0]  m_hi;
  logic [7:0]  m_lo;

  task automatic model_op(input logic op, input logic [3:0] pair, input logic [15:0] sp);
    logic [15:0] a0, a1;
    exp_q.delete();
    m_op   = op;
    m_pair = pair & 4'hE;
    if (!op) begin
      a0   = sp - 16'd1;
      a1   = sp - 16'd2;
      m_hi = exp_rf[m_pair];
      m_lo = exp_rf[m_pair | 4'd1];
      exp_q.push_back({1'b1, a0, m_hi});
      exp_q.push_back({1'b1, a1, m_lo});
      exp_mem[a0] = m_hi;
      exp_mem[a1] = m_lo;
      m_sp  = a1;
      m_lat = 3;
    end else begin
      a0   = sp;
      a1   = sp + 16'd1;
      m_lo = exp_mem[a0];
      m_hi = exp_mem[a1];
      exp_q.push_back({1'b0, a0, m_lo});
      exp_q.push_back({1'b0, a1, m_hi});
      exp_rf[m_pair]        = m_hi;
      exp_rf[m_pair | 4'd1] = m_lo;
      if (m_pair == 4'd6) exp_flag = m_lo & 8'hF0;
      m_sp  = sp + 16'd2;
      m_lat = 4;
    end
  endtask

  task automatic wait_done(input string tag, input bit chk_lat, input int d0, input int w0, input int xb);
    int cyc;
    cyc = 1;
    while (!bus.done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".done"}, bus.done, 1'b1);
    if (chk_lat) check({tag, ".lat"}, cyc, m_lat);
    check({tag, ".sp_out"}, bus.sp_out, m_sp);
    check({tag, ".sp_we"}, bus.sp_we, 1'b1);
    #1;
    check({tag, ".ndone"}, done_cnt - d0, 1);
    check({tag, ".nxfer"}, xq.size() - xb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (xb + i < xq.size()) check({tag, ".xfer"}, xq[xb + i], exp_q[i]);
    check({tag, ".nwr"}, wr_cnt - w0, {31'd0, m_op});
    if (m_op) begin
      check({tag, ".wr_reg"}, last_wr_reg, m_pair);
      check({tag, ".wr_data"}, last_wr_data, {m_hi, m_lo});
      check({tag, ".rf_hi"}, env_rf[m_pair], exp_rf[m_pair]);
      check({tag, ".rf_lo"}, env_rf[m_pair | 4'd1], exp_rf[m_pair | 4'd1]);
      check({tag, ".wr_flag"}, last_wr_flag, m_pair == 4'd6);
      if (m_pair == 4'd6) begin
        check({tag, ".flag_data"}, last_flag_data, m_lo & 8'hF0);
        check({tag, ".rdflag"}, env_flag, exp_flag);
      end
    end
    check({tag, ".excl"}, excl_err, 0);
  endtask

  task automatic run_op(input string tag, input logic op, input logic [3:0] pair, input logic [15:0] sp);
    int d0, w0, xb;
    model_op(op, pair, sp);
    @(negedge clk);
    d0 = done_cnt;
    w0 = wr_cnt;
    xb = xq.size();
    bus.start = 1'b1;
    bus.op    = op;
    bus.pair  = pair;
    bus.sp_in = sp;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(tag, ready_mode == 0, d0, w0, xb);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, ".busy"}, bus.busy, 0);
    check({tag, ".done"}, bus.done, 0);
    check({tag, ".sp_out"}, bus.sp_out, 0);
    check({tag, ".sp_we"}, bus.sp_we, 0);
    check({tag, ".rf_rd_reg"}, bus.rf_rd_reg, 0);
    check({tag, ".rf_wr_en"}, bus.rf_wr_en, 0);
    check({tag, ".rf_wr_reg"}, bus.rf_wr_reg, 0);
    check({tag, ".rf_wr_data"}, bus.rf_wr_data, 0);
    check({tag, ".rf_wr_flag"}, bus.rf_wr_flag, 0);
    check({tag, ".rf_flag_data"}, bus.rf_flag_data, 0);
    check({tag, ".mem_addr"}, bus.mem_addr, 0);
    check({tag, ".mem_wdata"}, bus.mem_wdata, 0);
    check({tag, ".mem_we"}, bus.mem_we, 0);
    check({tag, ".mem_re"}, bus.mem_re, 0);
  endtask

  task automatic sync_env();
    sync_gen++;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, xb;
    logic [15:0] a_hold;
    logic [7:0]  d_hold, rf0, rf1;

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.pair  = 4'd0;
    bus.sp_in = 16'd0;
    for (int i = 0; i < 65536; i++) exp_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) exp_rf[i] = 8'($urandom);
    exp_flag = 8'h00;
    sync_env();
    repeat (2) @(negedge clk);
    outputs_zero("reset");
    rst = 1'b1;

    // PUSH BC
    exp_rf[0] = 8'h12;
    exp_rf[1] = 8'h34;
    sync_env();
    run_op("push_bc", 1'b0, 4'd0, 16'hFFFE);
    check("push_bc.mem_hi", env_mem[16'hFFFD], 8'h12);
    check("push_bc.mem_lo", env_mem[16'hFFFC], 8'h34);

    // POP DE
    exp_mem[16'hC000] = 8'hCD;
    exp_mem[16'hC001] = 8'hAB;
    sync_env();
    run_op("pop_de", 1'b1, 4'd2, 16'hC000);
    check("pop_de.data", last_wr_data, 16'hABCD);

    // POP AF with an all-ones flag byte
    exp_mem[16'h8000] = 8'hFF;
    exp_mem[16'h8001] = 8'h5A;
    sync_env();
    run_op("pop_af", 1'b1, 4'd6, 16'h8000);
    check("pop_af.rdflag_const", env_flag, 8'hF0);

    // Wrap-around in both directions
    run_op("push_wrap", 1'b0, 4'd4, 16'h0000);
    run_op("pop_wrap", 1'b1, 4'd2, 16'hFFFF);

    // Stall in PUSH_HI with a second start that must be ignored
    model_op(1'b0, 4'd2, 16'h8000);
    ready_mode = 2;
    @(negedge clk);
    d0 = done_cnt;
    w0 = wr_cnt;
    xb = xq.size();
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.pair  = 4'd2;
    bus.sp_in = 16'h8000;
    @(negedge clk);
    bus.start = 1'b0;
    a_hold = bus.mem_addr;
    d_hold = bus.mem_wdata;
    check("stall.addr0", a_hold, 16'h7FFF);
    check("stall.wdata0", d_hold, exp_rf[2]);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 1);
      bus.op    = 1'b1;
      bus.pair  = 4'd4;
      bus.sp_in = 16'h1234;
      @(negedge clk);
      check("stall.addr", bus.mem_addr, a_hold);
      check("stall.wdata", bus.mem_wdata, d_hold);
      check("stall.busy", bus.busy, 1'b1);
      check("stall.done", bus.done, 1'b0);
    end
    bus.start  = 1'b0;
    ready_mode = 0;
    wait_done("stall", 1'b0, d0, w0, xb);
    repeat (10) @(negedge clk);
    check("stall.one_done", done_cnt - d0, 1);

    // Reset asserted during POP_HI
    rf0 = env_rf[0];
    rf1 = env_rf[1];
    @(negedge clk);
    d0 = done_cnt;
    w0 = wr_cnt;
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.pair  = 4'd0;
    bus.sp_in = 16'h4000;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort.in_pop_hi", {bus.mem_re, bus.mem_addr}, {1'b1, 16'h4001});
    #1 rst = 1'b0;
    #1 outputs_zero("abort");
    repeat (3) @(negedge clk);
    check("abort.ndone", done_cnt - d0, 0);
    check("abort.nwr", wr_cnt - w0, 0);
    check("abort.rf_hi", env_rf[0], rf0);
    check("abort.rf_lo", env_rf[1], rf1);
    rst = 1'b1;
    run_op("after_abort", 1'b0, 4'd0, 16'h2000);

    // Random operations with random memory latency
    for (int n = 0; n < 40; n++) begin
      ready_mode = int'($urandom_range(0, 1));
      run_op("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Sequencer for PUSH rr / POP rr. It reads a register pair from the regfile, or writes one back to it.
- Moves the pair to or from external memory as two byte transfers addressed by SP.
- Sits between the control decoder and the regfile/memory bus, and returns the updated SP.
- Drives the regfile write port, including the flag write path for POP AF.

Parameters:
- PAIR_AF, 6: even regfile index of the A/F pair; the low byte of this pair maps to flags.
- FLAG_MASK, 8'hF0: mask applied to the flag byte on POP AF; the lower nibble always reads 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  1  0 = PUSH, 1 = POP
- pair  in  4  even regfile index of the high byte; bit 0 is ignored (forced 0)
- sp_in  in  16  current SP, sampled with start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- sp_out  out  16  new SP, valid while sp_we = 1
- sp_we  out  1  one-cycle SP update strobe, coincident with done
- rf_rd_reg  out  4  regfile read select, connects to rdReg1
- rf_rd_hi  in  8  rdData1
- rf_rd_lo  in  8  rdData1Lo
- rf_wr_en  out  2  regfile writeEn
- rf_wr_reg  out  4  regfile wrReg
- rf_wr_data  out  16  regfile wrData as {hi, lo}
- rf_wr_flag  out  1  regfile writeFlag
- rf_flag_data  out  8  regfile flagData
- mem_addr  out  16  byte address
- mem_wdata  out  8  write data
- mem_we  out  1  write request
- mem_re  out  1  read request
- mem_rdata  in  8  read data, valid when mem_ready = 1
- mem_ready  in  1  completes the current mem_we/mem_re transfer

Behaviour:
- Reset (rst = 0, async): state IDLE. Every output is 0, including the registered rf_rd_reg, sp_out, mem_addr and rf_wr_data.
- States: IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, WB, DONE.
- IDLE:
  - start = 1 latches sp_in into an internal sp register and pair & 4'hE into a pair register; rf_rd_reg is driven to the pair.
  - Next state: PUSH_HI if op = 0, POP_LO if op = 1.
  - start is ignored in every other state; no queueing.
- PUSH_HI:
  - mem_we = 1, mem_addr = sp-1, mem_wdata = rf_rd_hi.
  - Hold all three until mem_ready = 1, then go to PUSH_LO.
- PUSH_LO:
  - mem_we = 1, mem_addr = sp-2, mem_wdata = rf_rd_lo.
  - On mem_ready: sp_out = sp-2, go to DONE.
- POP_LO:
  - mem_re = 1, mem_addr = sp.
  - On mem_ready: capture mem_rdata as lo, go to POP_HI.
- POP_HI:
  - mem_re = 1, mem_addr = sp+1.
  - On mem_ready: capture hi, sp_out = sp+2, go to WB.
- WB (exactly one cycle):
  - rf_wr_en = 2'b11, rf_wr_reg = pair, rf_wr_data = {hi, lo}.
  - If pair == PAIR_AF, additionally rf_wr_flag = 1 and rf_flag_data = lo & FLAG_MASK.
  - Go to DONE.
- DONE (one cycle): done = 1, sp_we = 1; return to IDLE.
- SP arithmetic is 16-bit modulo 2^16:
  - PUSH with sp = 0x0000 writes 0xFFFF then 0xFFFE, and sp_out = 0xFFFE.
  - POP with sp = 0xFFFF reads 0xFFFF then 0x0000, and sp_out = 0x0001.
- Request strobes:
  - mem_we and mem_re are never high together.
  - After a strobe sees mem_ready it is deasserted for at least the state change; back-to-back transfers are allowed.
- mem_ready = 0 stalls indefinitely. All outputs hold and busy stays high.
- Latency with mem_ready tied to 1:
  - PUSH: done 3 cycles after start.
  - POP: done 4 cycles after start.
- rf_rd_reg holds the pair for the whole PUSH. rf_rd_hi/lo are sampled in the transfer state, since the regfile read is combinational.
- Reset asserted mid-operation:
  - Aborts immediately with no further memory or regfile writes and no done/sp_we.
  - Bytes already written stay in memory.
- The regfile write port is idle (all 0) outside WB.

Decomposition:
- Shared package gb_pkg holds:
  - regfile index constants: REG_B..REG_L, PAIR_BC/DE/HL/AF, REG_SP;
  - writeEn encodings: WE_NONE = 2'b00, WE_PAIR = 2'b11;
  - state typedef stack_state_t.
- No sub-module. The SP ±1/±2 adder is inline.

Test Plan:
- PUSH BC, B = 0x12, C = 0x34, sp_in = 0xFFFE, mem_ready = 1 -> writes [0xFFFD] = 0x12, [0xFFFC] = 0x34; done and sp_we at start+3 with sp_out = 0xFFFC; regfile unchanged.
- POP DE, mem [0xC000] = 0xCD, [0xC001] = 0xAB, sp_in = 0xC000 -> WB writes wrReg = PAIR_DE, wrData = 0xABCD; sp_out = 0xC002; done at start+4.
- POP AF, memory lo = 0xFF, hi = 0x5A -> rf_wr_data = 0x5AFF, rf_wr_flag = 1 and rf_flag_data = 0xF0 in the same cycle; rdFlag reads 0xF0 afterwards.
- Wrap-around:
  - PUSH HL at sp_in = 0x0000 -> addresses 0xFFFF, 0xFFFE; sp_out = 0xFFFE.
  - POP at sp_in = 0xFFFF -> addresses 0xFFFF, 0x0000; sp_out = 0x0001.
- Stall and busy: mem_ready held 0 for 5 cycles in PUSH_HI -> mem_addr and mem_wdata stable, busy = 1, done = 0; a second start during busy is ignored (exactly one done).
- Reset mid-operation: rst low during POP_HI -> all outputs 0 within the same cycle (async), no rf_wr_en, no done; after release, a fresh PUSH completes normally.
